hwa: RTL and testbench

Stochastic-computing FIR hardware accelerator: an 18th-order (19-tap) low-pass FIR filter on a 12-bit unsigned sample stream. Samples arrive on a slow sampling strobe, nominally one per 4096 digital clocks. Each output is computed by converting the tap products into a stochastic bitstream and counting its ones over one 4096-cycle window. The block sits between the sample source (ADC-side register) and the downstream consumer, which latches `out` when `done` pulses.

---
 rtl/hwa.sv | 118 +++++++++++
 tb/tb_hwa.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hwa.sv
// Purpose : stochastic-computing 19-tap low-pass FIR on a 12-bit unsigned sample stream.
// Latency : result for a sample window appears 4096 clock_d cycles after the strobe that opened it.
// Backpr. : none; the source sets the rate through clock_s and the consumer latches out on done.
//
// Ports:
//   clock_d  digital clock; every register updates on its rising edge
//   reset    synchronous active-high reset
//   in       unsigned sample, captured on a clock_s rising edge
//   clock_s  sampling strobe level, synchronous to clock_d
//   out      filtered sample, held between updates
//   done     one-cycle pulse when out is updated
module hwa #(
  parameter int N     = 12,
  parameter int ORDER = 18
) (
  input  logic         clock_d,
  input  logic         reset,
  input  logic [N-1:0] in,
  input  logic         clock_s,
  output logic [N-1:0] out,
  output logic         done
);

  localparam int TAPS = ORDER + 1;
  localparam int SELW = $clog2(TAPS);

  // Tap weights: tap 0 is slightly lighter so the set sums to exactly 2^N.
  function automatic logic [N:0] coef(input int k);
    return (k == 0) ? (N+1)'(208) : (N+1)'(216);
  endfunction

  // Cumulative weight bound C_k = coef(0) + ... + coef(k).
  function automatic logic [N:0] cbound(input int k);
    logic [N:0] s;
    s = '0;
    for (int i = 0; i <= k; i++) s = s + coef(i);
    return s;
  endfunction

  logic [N-1:0] x [TAPS];
  logic         s_q;
  logic         strobe;
  logic [N-1:0] l_sel;
  logic [N-1:0] l_cmp;
  logic         fb_sel;
  logic         fb_cmp;
  logic [SELW-1:0] sel;
  logic         b;
  logic [N:0]   cnt;
  logic [N-1:0] ph;
  logic         active;
  logic [N:0]   cnt_next;
  logic [N-1:0] out_sat;

  assign strobe = clock_s & ~s_q;

  // Fibonacci feedback: x^12+x^11+x^10+x^4+1 and x^12+x^6+x^4+x+1.
  // Both include the top tap, so the state map is invertible and a non-zero
  // seed never reaches the all-zero lock-up state.
  assign fb_sel = l_sel[11] ^ l_sel[10] ^ l_sel[9] ^ l_sel[3];
  assign fb_cmp = l_cmp[11] ^ l_cmp[5]  ^ l_cmp[3] ^ l_cmp[0];

  // Smallest k with l_sel < C_k; scanning downward leaves the smallest winner.
  // C_ORDER = 2^N exceeds every l_sel value, so the last tap is the fallback.
  always_comb begin
    sel = SELW'(TAPS - 1);
    for (int k = TAPS - 1; k >= 0; k--) begin
      if ({1'b0, l_sel} < cbound(k)) sel = SELW'(k);
    end
  end

  // One stream bit: selected tap compared against an independent uniform value.
  assign b = (x[sel] > l_cmp);

  assign cnt_next = cnt + {{N{1'b0}}, b};
  // A full window of ones gives 2^N, one past the output range.
  assign out_sat  = cnt_next[N] ? {N{1'b1}} : cnt_next[N-1:0];

  always_ff @(posedge clock_d) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      s_q    <= 1'b0;
      l_sel  <= 12'hACE;
      l_cmp  <= 12'h5A5;
      cnt    <= '0;
      ph     <= '0;
      active <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      s_q   <= clock_s;
      l_sel <= {l_sel[N-2:0], fb_sel};
      l_cmp <= {l_cmp[N-2:0], fb_cmp};
      done  <= 1'b0;

      if (active) begin
        cnt <= cnt_next;
        ph  <= ph + 1'b1;
        if (ph == {N{1'b1}}) begin
          out    <= out_sat;
          done   <= 1'b1;
          active <= 1'b0;
        end
      end

      // A strobe overrides the accumulator update: the final-edge result has
      // already been captured above, and any unfinished window is dropped.
      if (strobe) begin
        x[0] <= in;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        cnt    <= '0;
        ph     <= '0;
        active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hwa.sv
// Purpose : directed bench for hwa with a scoreboard of expected window results.
// Latency : each expected entry carries the exact cycle its done pulse must appear.
// Backpr. : none; the bench drives clock_s and checks every done pulse.
module tb_hwa;

  logic        clock_d;
  logic        reset;
  logic [11:0] in;
  logic        clock_s;
  logic [11:0] out;
  logic        done;

  hwa dut (
    .clock_d (clock_d),
    .reset   (reset),
    .in      (in),
    .clock_s (clock_s),
    .out     (out),
    .done    (done)
  );

  initial clock_d = 1'b0;
  always #5 clock_d = ~clock_d;

  typedef struct {
    int cyc;
    int lo;
    int hi;
  } exp_t;

  exp_t q[$];
  int   hist[19];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clock_d) cyc <= cyc + 1;

  function automatic int coef(input int k);
    return (k == 0) ? 208 : 216;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest entry in time and value,
  // and an entry whose cycle passes without done is reported as missing.
  always @(negedge clock_d) begin
    exp_t e;
    logic ok;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        ok = (int'(out) >= e.lo) && (int'(out) <= e.hi);
        n_vec++;
        assert (ok === 1'b1) else begin
          n_err++;
          $error("FAIL out_window: observed %0d expected %0d..%0d", out, e.lo, e.hi);
        end
      end
    end else if (q.size() > 0 && cyc >= q[0].cyc) begin
      e = q.pop_front();
      chk("missing_done", 0, 1);
    end
  end

  // Drive one strobe with sample val; the next strobe is driven gap cycles later.
  // Only windows allowed to run their full 4096 cycles are put on the scoreboard.
  task automatic do_strobe(input int val, input int gap);
    int sum;
    int e;
    int lo;
    int hi;
    bit allfull;
    @(negedge clock_d);
    in      = val[11:0];
    clock_s = 1'b1;
    for (int k = 18; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = val;
    sum     = 0;
    allfull = 1'b1;
    for (int k = 0; k < 19; k++) begin
      sum = sum + coef(k) * hist[k];
      if (hist[k] != 4095) allfull = 1'b0;
    end
    e = sum / 4096;
    if (sum == 0) begin
      lo = 0;
      hi = 0;
    end else if (allfull) begin
      lo = 4000;
      hi = 4095;
    end else begin
      lo = (e > 64) ? e - 64 : 0;
      hi = (e + 64 < 4095) ? e + 64 : 4095;
    end
    // Strobe edge is the next posedge (cyc+1); done is sampled 4096 edges later.
    if (gap >= 4096) q.push_back('{cyc + 4097, lo, hi});
    @(negedge clock_d);
    clock_s = 1'b0;
    repeat (gap - 2) @(negedge clock_d);
  endtask

  initial begin
    reset   = 1'b1;
    clock_s = 1'b0;
    in      = '0;
    for (int k = 0; k < 19; k++) hist[k] = 0;

    // Reset held for three cycles while clock_s toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_d);
      clock_s = ~clock_s;
      chk("reset_out", int'(out), 0);
      chk("reset_done", int'(done), 0);
    end
    @(negedge clock_d);
    clock_s = 1'b0;
    reset   = 1'b0;

    // Start-up: no strobe, so out stays 0 and no done appears.
    repeat (100) @(negedge clock_d);
    chk("startup_out", int'(out), 0);

    // All-zero input at the nominal rate.
    do_strobe(0, 4096);
    do_strobe(0, 4096);

    // Impulse: tap 0 weight, tap 1 weight, slide to tap 18, then fall out.
    do_strobe(4095, 4096);
    do_strobe(0, 4096);
    for (int i = 0; i < 16; i++) do_strobe(0, 4);
    do_strobe(0, 4096);
    do_strobe(0, 4096);

    // Strobe mid-window: the first window is dropped, the second completes.
    do_strobe(0, 1000);
    do_strobe(4095, 4096);

    // Full scale: fill the delay line with abandoned short windows, then run full ones.
    for (int i = 0; i < 17; i++) do_strobe(4095, 4);
    do_strobe(4095, 4096);
    do_strobe(4095, 4096);
    do_strobe(4095, 4100);

    // Reset mid-window: no done, out cleared, taps cleared for the next window.
    do_strobe(4095, 2000);
    reset = 1'b1;
    @(negedge clock_d);
    @(negedge clock_d);
    chk("midreset_out", int'(out), 0);
    chk("midreset_done", int'(done), 0);
    reset = 1'b0;
    for (int k = 0; k < 19; k++) hist[k] = 0;
    repeat (50) @(negedge clock_d);
    chk("post_reset_out", int'(out), 0);
    do_strobe(0, 4100);

    // Drain anything still outstanding, with a bound.
    for (int i = 0; i < 5000 && q.size() > 0; i++) @(negedge clock_d);
    chk("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
